cordic_result_writer: RTL and testbench

- Downstream stage of the CORDIC engine: takes its `valid_out`/`result` stream and writes each result to consecutive result-SRAM addresses.
- Buffers results in a small FIFO to absorb SRAM write stalls (`mem_ready` low). The engine has no backpressure, so the buffer is required.
- Counts results against a programmed total, raises `done` when the last one is written, and flags any dropped results.

---
 rtl/cordic_result_writer_if.sv | 32 +++
 rtl/cordic_result_writer.sv | 175 +++++++++++++++++
 tb/tb_cordic_result_writer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_result_writer_if.sv
// Result-stream and SRAM write-port bundle for cordic_result_writer.
// Latency: none (wires only).
// Backpressure: the result stream has none; the write side stalls on mem_ready.
//
// Signals:
//   valid_in / result_in : engine result stream (no backpressure)
//   mem_ready            : SRAM accepts the write this cycle
//   mem_wen/addr/wdata   : SRAM write request, address and data
// Modports:
//   slave  : writer view (consumes the stream, drives the SRAM port)
//   master : environment view (engine + SRAM)
interface cordic_result_writer_if #(
  parameter int IO_BW   = 32,
  parameter int ADDR_BW = 10
);
  logic               valid_in;
  logic [IO_BW-1:0]   result_in;
  logic               mem_ready;
  logic               mem_wen;
  logic [ADDR_BW-1:0] mem_addr;
  logic [IO_BW-1:0]   mem_wdata;

  modport slave (
    input  valid_in, result_in, mem_ready,
    output mem_wen, mem_addr, mem_wdata
  );

  modport master (
    output valid_in, result_in, mem_ready,
    input  mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cordic_result_writer.sv
// Writes CORDIC results to consecutive SRAM addresses through a small FIFO.
// Latency: a result pushed at edge N is presented on the SRAM port after edge N.
// Backpressure: mem_ready low stalls writes; results arriving on a full FIFO are dropped.
//
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   start           : one-cycle job start, honoured in IDLE only
//   base_addr       : first SRAM address of the job (latched on start)
//   num_results     : results in the job (latched on start)
//   bus (slave)     : result stream in, SRAM write port out
//   busy            : job running
//   done            : one-cycle pulse once the last result is written
//   overflow        : sticky, a result was dropped on a full FIFO
//   written_cnt     : results written in the current job
module cordic_result_writer #(
  parameter int IO_BW      = 32,
  parameter int ADDR_BW    = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_BW-1:0]     base_addr,
  input  logic [ADDR_BW-1:0]     num_results,
  cordic_result_writer_if.slave  bus,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [ADDR_BW-1:0]     written_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_BW-1:0] base_q, base_d;
  logic [ADDR_BW-1:0] num_q, num_d;
  logic [ADDR_BW-1:0] accepted_q, accepted_d;
  logic [ADDR_BW-1:0] written_q, written_d;
  logic               overflow_q, overflow_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Storage carries no reset: the pointers and count define what is valid.
  logic [IO_BW-1:0]   fifo_mem_q [FIFO_DEPTH];

  logic run;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic want_push;
  logic push;
  logic drop;

  assign run        = (state_q == ST_RUN);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));

  // A write completes when the head is offered and the SRAM takes it.
  assign pop        = run && !fifo_empty && bus.mem_ready;

  // Results beyond the programmed total are discarded without flagging.
  assign want_push  = run && bus.valid_in && (accepted_q < num_q);

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push       = want_push && (!fifo_full || pop);
  assign drop       = want_push && fifo_full && !pop;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    num_d      = num_q;
    accepted_d = accepted_q;
    written_d  = written_q;
    overflow_d = overflow_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d     = base_addr;
          num_d      = num_results;
          accepted_d = '0;
          written_d  = '0;
          overflow_d = 1'b0;
          rd_ptr_d   = '0;
          wr_ptr_d   = '0;
          count_d    = '0;
          state_d    = (num_results == '0) ? ST_DONE : ST_RUN;
        end
      end

      ST_RUN: begin
        if (push) begin
          accepted_d = accepted_q + ADDR_BW'(1);
          wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_d  = rd_ptr_q + PTR_W'(1);
          written_d = written_q + ADDR_BW'(1);
          // num_q is non-zero in RUN, so this cannot wrap falsely.
          if ((written_q + ADDR_BW'(1)) == num_q) begin
            state_d = ST_DONE;
          end
        end
        if (drop) begin
          overflow_d = 1'b1;
        end
        case ({push, pop})
          2'b10:   count_d = count_q + CNT_W'(1);
          2'b01:   count_d = count_q - CNT_W'(1);
          default: count_d = count_q;
        endcase
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      num_q      <= '0;
      accepted_q <= '0;
      written_q  <= '0;
      overflow_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      num_q      <= num_d;
      accepted_q <= accepted_d;
      written_q  <= written_d;
      overflow_q <= overflow_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= bus.result_in;
    end
  end

  // SRAM port is quiet (all zero) outside RUN; the address wraps naturally.
  assign bus.mem_wen   = run && !fifo_empty;
  assign bus.mem_wdata = run ? fifo_mem_q[rd_ptr_q] : '0;
  assign bus.mem_addr  = run ? (base_q + written_q) : '0;

  assign busy        = run;
  assign done        = (state_q == ST_DONE);
  assign overflow    = overflow_q;
  assign written_cnt = written_q;

endmodule

// File: tb/tb_cordic_result_writer.sv
module tb_cordic_result_writer;

  localparam int IO_BW      = 32;
  localparam int ADDR_BW    = 10;
  localparam int FIFO_DEPTH = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [ADDR_BW-1:0] base_addr;
  logic [ADDR_BW-1:0] num_results;
  logic               busy;
  logic               done;
  logic               overflow;
  logic [ADDR_BW-1:0] written_cnt;

  cordic_result_writer_if #(.IO_BW(IO_BW), .ADDR_BW(ADDR_BW)) bus ();

  cordic_result_writer #(
    .IO_BW(IO_BW), .ADDR_BW(ADDR_BW), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .num_results(num_results),
    .bus(bus),
    .busy(busy),
    .done(done),
    .overflow(overflow),
    .written_cnt(written_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_BW-1:0] addr;
    logic [IO_BW-1:0]   data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  tests = 0;
  int  fails = 0;
  int  done_pulses = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: a write completes on the next rising edge when wen && ready.
  always @(negedge clk) begin
    if (done === 1'b1) done_pulses++;
    if (rst === 1'b0 && bus.mem_wen === 1'b1 && bus.mem_ready === 1'b1) begin
      check("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(bus.mem_addr), 64'(mon_e.addr));
        check("wr_data", 64'(bus.mem_wdata), 64'(mon_e.data));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_job(input logic [ADDR_BW-1:0] b, input logic [ADDR_BW-1:0] n);
    start = 1'b1;
    base_addr = b;
    num_results = n;
    tick();
    start = 1'b0;
  endtask

  // Leaves valid_in high so consecutive calls form a back-to-back stream.
  task automatic send(input logic [IO_BW-1:0] d, input bit expect_wr, input logic [ADDR_BW-1:0] a);
    bus.valid_in = 1'b1;
    bus.result_in = d;
    if (expect_wr) exp_q.push_back('{addr: a, data: d});
    tick();
  endtask

  task automatic wait_done(input string tag, input int limit, output int n);
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_wen"}, 64'(bus.mem_wen), 64'd0);
    check({tag, "_addr"}, 64'(bus.mem_addr), 64'd0);
    check({tag, "_wdata"}, 64'(bus.mem_wdata), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_ovf"}, 64'(overflow), 64'd0);
    check({tag, "_wcnt"}, 64'(written_cnt), 64'd0);
  endtask

  initial begin
    int n;
    int pre;
    logic [ADDR_BW-1:0] a;

    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    num_results = '0;
    bus.valid_in = 1'b0;
    bus.result_in = '0;
    bus.mem_ready = 1'b0;
    tick();
    tick();
    check_reset("reset");
    rst = 1'b0;

    // Basic job with first-write latency and done timing.
    bus.mem_ready = 1'b1;
    pre = done_pulses;
    start_job(10'h010, 10'd4);
    check("basic_busy", 64'(busy), 64'd1);
    check("basic_wen_before", 64'(bus.mem_wen), 64'd0);
    send(32'hA, 1'b1, 10'h010);
    check("basic_wen_lat", 64'(bus.mem_wen), 64'd1);
    check("basic_addr_lat", 64'(bus.mem_addr), 64'h010);
    check("basic_data_lat", 64'(bus.mem_wdata), 64'hA);
    for (int i = 1; i < 4; i++) send(32'hA + 32'(i), 1'b1, 10'h010 + 10'(i));
    bus.valid_in = 1'b0;
    wait_done("basic", 20, n);
    check("basic_done_lat", 64'(n), 64'd1);
    check("basic_done_wen", 64'(bus.mem_wen), 64'd0);
    tick();
    check("basic_done_once", 64'(done_pulses - pre), 64'd1);
    check("basic_done_low", 64'(done), 64'd0);
    check("basic_ovf", 64'(overflow), 64'd0);
    check("basic_wcnt", 64'(written_cnt), 64'd4);

    // Stall: fill all 8 entries while the SRAM is not ready.
    bus.mem_ready = 1'b0;
    start_job(10'h020, 10'd8);
    for (int i = 0; i < 8; i++) send(32'h100 + 32'(i), 1'b1, 10'h020 + 10'(i));
    bus.valid_in = 1'b0;
    check("stall_ovf", 64'(overflow), 64'd0);
    check("stall_wen", 64'(bus.mem_wen), 64'd1);
    check("stall_wcnt", 64'(written_cnt), 64'd0);
    bus.mem_ready = 1'b1;
    wait_done("stall", 30, n);
    check("stall_drain_cycles", 64'(n), 64'd8);
    tick();
    check("stall_wcnt_end", 64'(written_cnt), 64'd8);

    // Overflow: 9th result dropped, flag sticky, job completes with 16 writes.
    bus.mem_ready = 1'b0;
    pre = done_pulses;
    start_job(10'h040, 10'd16);
    for (int i = 0; i < 9; i++) send(32'h200 + 32'(i), i < 8, 10'h040 + 10'(i));
    bus.valid_in = 1'b0;
    check("ovf_set", 64'(overflow), 64'd1);
    bus.mem_ready = 1'b1;
    tick();
    tick();
    tick();
    check("ovf_sticky", 64'(overflow), 64'd1);
    check("ovf_wcnt_mid", 64'(written_cnt), 64'd3);
    for (int j = 0; j < 8; j++) send(32'h300 + 32'(j), 1'b1, 10'h048 + 10'(j));
    bus.valid_in = 1'b0;
    check("ovf_no_early_done", 64'(done_pulses - pre), 64'd0);
    wait_done("ovf", 30, n);
    tick();
    check("ovf_wcnt_end", 64'(written_cnt), 64'd16);
    check("ovf_hold_idle", 64'(overflow), 64'd1);

    // Full FIFO with a simultaneous pop accepts the push; occupancy stays 8.
    bus.mem_ready = 1'b0;
    start_job(10'h060, 10'd10);
    for (int i = 0; i < 8; i++) send(32'h400 + 32'(i), 1'b1, 10'h060 + 10'(i));
    bus.mem_ready = 1'b1;
    send(32'h408, 1'b1, 10'h068);
    bus.mem_ready = 1'b0;
    check("fullpop_no_ovf", 64'(overflow), 64'd0);
    send(32'h4FF, 1'b0, 10'h000);
    check("fullpop_still_full", 64'(overflow), 64'd1);
    bus.mem_ready = 1'b1;
    send(32'h409, 1'b1, 10'h069);
    bus.valid_in = 1'b0;
    wait_done("fullpop", 30, n);
    tick();
    check("fullpop_wcnt", 64'(written_cnt), 64'd10);

    // num_results == 0: straight to DONE, start clears overflow.
    pre = done_pulses;
    start_job(10'h123, 10'd0);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    check("zero_wen", 64'(bus.mem_wen), 64'd0);
    check("zero_ovf_clr", 64'(overflow), 64'd0);
    check("zero_wcnt", 64'(written_cnt), 64'd0);
    tick();
    check("zero_done_once", 64'(done_pulses - pre), 64'd1);

    // Address wrap plus extra results past the programmed total.
    pre = done_pulses;
    start_job(10'h3FE, 10'd4);
    for (int i = 0; i < 4; i++) begin
      a = 10'h3FE + 10'(i);
      send(32'h500 + 32'(i), 1'b1, a);
    end
    send(32'h5AA, 1'b0, 10'h000);
    send(32'h5AB, 1'b0, 10'h000);
    bus.valid_in = 1'b0;
    tick();
    tick();
    check("wrap_done_once", 64'(done_pulses - pre), 64'd1);
    check("wrap_extra_no_ovf", 64'(overflow), 64'd0);
    check("wrap_wcnt", 64'(written_cnt), 64'd4);

    // Reset after 2 of 6 writes, then a clean short job.
    bus.mem_ready = 1'b0;
    start_job(10'h080, 10'd6);
    for (int i = 0; i < 6; i++) send(32'h600 + 32'(i), i < 2, 10'h080 + 10'(i));
    bus.valid_in = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    bus.mem_ready = 1'b0;
    check("midrst_wcnt_pre", 64'(written_cnt), 64'd2);
    rst = 1'b1;
    tick();
    check_reset("midrst");
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    start_job(10'h100, 10'd2);
    send(32'h700, 1'b1, 10'h100);
    send(32'h701, 1'b1, 10'h101);
    bus.valid_in = 1'b0;
    wait_done("after_rst", 10, n);
    tick();
    check("after_rst_wcnt", 64'(written_cnt), 64'd2);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
